// File: rtl/logisim_multi_tick_generator.sv
// Base tick generator with run/step modes and a debounced step button, fanned out
// to NR_OF_CHANNELS clock components that each drive a 5-bit clock bus.
module logisim_multi_tick_generator #(
  parameter int NR_OF_BITS      = 32,
  parameter int RELOAD_FAST     = 3125000,
  parameter int RELOAD_SLOW     = 12500000,
  parameter int NR_OF_CHANNELS  = 2,
  parameter int HIGH_TICKS      = 1,
  parameter int LOW_TICKS       = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COUNT_BITS      = 32
) (
  input  logic                        FPGA_GlobalClock,
  input  logic                        RST,
  input  logic                        RUN,
  input  logic                        SPEED,
  input  logic                        STEP,
  output logic                        TICK,
  output logic [5*NR_OF_CHANNELS-1:0] CLOCK_BUS,
  output logic [COUNT_BITS-1:0]       CYCLE_COUNT
);

  localparam logic [NR_OF_BITS-1:0] FAST_LOAD = NR_OF_BITS'(RELOAD_FAST - 1);
  localparam logic [NR_OF_BITS-1:0] SLOW_LOAD = NR_OF_BITS'(RELOAD_SLOW - 1);
  localparam logic [31:0]           DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);

  logic [NR_OF_BITS-1:0] tick_cnt;
  logic [NR_OF_BITS-1:0] reload;
  logic                  step_meta;
  logic                  step_sync;
  logic                  step_db;
  logic [31:0]           db_cnt;
  logic                  db_accept;

  logic [NR_OF_CHANNELS-1:0] level;
  logic [NR_OF_CHANNELS-1:0] rise;
  logic [NR_OF_CHANNELS-1:0] fall;
  logic [31:0]               phase [NR_OF_CHANNELS];

  function automatic logic [31:0] span(int ticks, int unsigned ch);
    return (32'(ticks) << ch) - 32'd1;
  endfunction

  assign reload    = SPEED ? FAST_LOAD : SLOW_LOAD;
  assign db_accept = (step_sync != step_db) && (db_cnt == DB_LAST);

  // A zero count always fires and reloads, even when RUN just dropped, so the
  // counter can never sit at zero while frozen.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      tick_cnt  <= reload;
      TICK      <= 1'b0;
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_db   <= 1'b0;
      db_cnt    <= '0;
    end else begin
      step_meta <= STEP;
      step_sync <= step_meta;
      if (step_sync == step_db) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        db_cnt  <= '0;
        step_db <= step_sync;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
      if (tick_cnt == '0) begin
        tick_cnt <= reload;
      end else if (RUN) begin
        tick_cnt <= tick_cnt - NR_OF_BITS'(1);
      end
      TICK <= (tick_cnt == '0) || (db_accept && step_sync && !RUN);
    end
  end

  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
        level[i] <= 1'b0;
        rise[i]  <= 1'b0;
        fall[i]  <= 1'b0;
        phase[i] <= span(LOW_TICKS, i);
      end
    end else begin
      for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (TICK) begin
          if (phase[i] == '0) begin
            level[i] <= ~level[i];
            rise[i]  <= ~level[i];
            fall[i]  <= level[i];
            phase[i] <= level[i] ? span(LOW_TICKS, i) : span(HIGH_TICKS, i);
          end else begin
            phase[i] <= phase[i] - 32'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      CYCLE_COUNT <= '0;
    end else if (rise[0]) begin
      CYCLE_COUNT <= CYCLE_COUNT + COUNT_BITS'(1);
    end
  end

  always_comb begin
    CLOCK_BUS = '0;
    for (int unsigned i = 0; i < NR_OF_CHANNELS; i++) begin
      CLOCK_BUS[5*i +: 5] = {TICK, fall[i], rise[i], ~level[i], level[i]};
    end
  end

endmodule

// File: tb/tb_logisim_multi_tick_generator.sv
// Bench for logisim_multi_tick_generator: directed scenarios plus random stimulus,
// every cycle compared with a tick-count based reference model.
module tb_logisim_multi_tick_generator;

  localparam int unsigned R_FAST = 4;
  localparam int unsigned R_SLOW = 10;
  localparam int unsigned DB     = 3;
  localparam int unsigned HT     = 1;
  localparam int unsigned LT     = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       speed = 1'b1;
  logic       step = 1'b0;
  logic       tick;
  logic [9:0] bus;
  logic [3:0] cc;

  int tests = 0;
  int fails = 0;

  logisim_multi_tick_generator #(
    .NR_OF_BITS(32),
    .RELOAD_FAST(4),
    .RELOAD_SLOW(10),
    .NR_OF_CHANNELS(2),
    .HIGH_TICKS(1),
    .LOW_TICKS(1),
    .DEBOUNCE_CYCLES(3),
    .COUNT_BITS(4)
  ) dut (
    .FPGA_GlobalClock(clk),
    .RST(rst),
    .RUN(run),
    .SPEED(speed),
    .STEP(step),
    .TICK(tick),
    .CLOCK_BUS(bus),
    .CYCLE_COUNT(cc)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: channel levels follow from the total number of ticks seen,
  // tick timing from elapsed cycles within the latched period.
  bit          m_tick;
  int unsigned m_n;
  bit [1:0]    m_lvl, m_rise, m_fall;
  int unsigned m_cc;
  int unsigned elapsed, period;
  bit          m_db;
  bit          raw[$];
  bit          sh[$];

  function automatic bit level_of(int unsigned n, int unsigned ch);
    int unsigned p;
    p = (HT + LT) << ch;
    return (n % p) >= (LT << ch);
  endfunction

  function automatic int unsigned remaining();
    return period - 1 - elapsed;
  endfunction

  task automatic model_edge();
    bit [1:0] nl;
    bit       rt_tick, st_tick, sync_now, all_diff;
    if (rst) begin
      raw = '{1'b0, 1'b0};
      sh.delete();
      m_db = 0; m_tick = 0; m_n = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_cc = 0;
      elapsed = 0;
      period = speed ? R_FAST : R_SLOW;
      return;
    end
    if (m_rise[0]) m_cc = (m_cc + 1) % 16;
    if (m_tick) m_n++;
    for (int i = 0; i < 2; i++) nl[i] = level_of(m_n, i);
    m_rise = nl & ~m_lvl;
    m_fall = ~nl & m_lvl;
    m_lvl  = nl;
    rt_tick = (elapsed == period - 1);
    if (rt_tick) begin
      elapsed = 0;
      period  = speed ? R_FAST : R_SLOW;
    end else if (run) begin
      elapsed++;
    end
    sync_now = raw.pop_front();
    raw.push_back(step);
    sh.push_back(sync_now);
    if (sh.size() > DB) void'(sh.pop_front());
    st_tick = 0;
    if (sh.size() == DB) begin
      all_diff = 1;
      foreach (sh[k]) if (sh[k] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = ~m_db;
        st_tick = m_db && !run;
      end
    end
    m_tick = rt_tick || st_tick;
  endtask

  function automatic logic [9:0] exp_bus();
    logic [9:0] b;
    for (int i = 0; i < 2; i++) b[5*i +: 5] = {m_tick, m_fall[i], m_rise[i], ~m_lvl[i], m_lvl[i]};
    return b;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("tick", {31'd0, tick}, {31'd0, m_tick});
    check("clock_bus", {22'd0, bus}, {22'd0, exp_bus()});
    check("cycle_count", {28'd0, cc}, m_cc);
  endtask

  initial begin
    int unsigned ticks[$];
    int unsigned exp_ticks[4] = '{4, 8, 18, 28};
    int n, at, k, r;

    // Reset, then fast run with a slow switch mid-period
    #1;
    rst = 1; run = 0; speed = 1; step = 0;
    repeat (2) cycle();
    rst = 0; run = 1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) speed = 0;
      cycle();
      if (tick) ticks.push_back(c);
    end
    check("tick_count", ticks.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ticks.size()) check("tick_cycle", ticks[i], exp_ticks[i]);

    // Step mode: short bounce ignored, held presses give one tick each
    run = 0;
    repeat (3) cycle();
    n = 0;
    step = 1;
    repeat (2) begin cycle(); n += int'(tick); end
    step = 0;
    repeat (8) begin cycle(); n += int'(tick); end
    check("bounce_ticks", n, 0);
    for (int p = 0; p < 2; p++) begin
      n = 0; at = 0;
      step = 1;
      for (int c = 1; c <= 10; c++) begin
        cycle();
        if (tick) begin n++; at = c; end
      end
      step = 0;
      repeat (8) begin cycle(); n += int'(tick); end
      check("step_ticks", n, 1);
      check("step_latency", at, 5);
    end

    // Freeze at count 2, then resume
    run = 1;
    k = 0;
    while (remaining() != 2 && k < 20) begin cycle(); k++; end
    run = 0;
    repeat (20) cycle();
    run = 1; at = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (tick && at == 0) at = c;
    end
    check("resume_latency", at, 3);

    // Mid-run reset and CYCLE_COUNT wrap
    speed = 1;
    repeat (3) cycle();
    rst = 1;
    cycle();
    check("rst_bus", {22'd0, bus}, 32'h042);
    rst = 0; at = 0; r = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (tick && at == 0) at = c;
      if (m_rise[0]) r++;
    end
    check("post_reset_first_tick", at, 4);
    k = 0;
    while (r < 16 && k < 300) begin
      cycle();
      if (m_rise[0]) r++;
      k++;
    end
    cycle();
    check("wrap", {28'd0, cc}, 0);

    // Random stimulus
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(19) == 0) run = ~run;
      if ($urandom_range(9) == 0) speed = ~speed;
      if ($urandom_range(5) == 0) step = ~step;
      rst = ($urandom_range(99) == 0);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logisim_multi_tick_generator.md
# logisim_multi_tick_generator

Parametrised clock-tree generator for the Logisim-derived FPGA toplevels: it replaces the fixed-reload tick generator and single clock component pair. It derives a base tick from `FPGA_GlobalClock` with two run-time selectable speeds and adds run/single-step/pause modes with a debounced step button. It fans the tick out to `NR_OF_CHANNELS` clock components, each exposing a 5-bit clock bus. The CPU toplevel (e.g. `single_cycle_riscv`) consumes channel 0 as `LOGISIM_CLOCK_TREE_0`.

## Interface
Parameters:
- `NR_OF_BITS`, 32: width of the tick reload counter.
- `RELOAD_FAST`, 3125000: global clocks per tick when `SPEED`=1; must be ≥2.
- `RELOAD_SLOW`, 12500000: global clocks per tick when `SPEED`=0; must be ≥2.
- `NR_OF_CHANNELS`, 2: number of clock components, 1..8.
- `HIGH_TICKS`, 1: ticks high for channel 0; channel i uses `HIGH_TICKS<<i`.
- `LOW_TICKS`, 1: ticks low for channel 0; channel i uses `LOW_TICKS<<i`.
- `DEBOUNCE_CYCLES`, 250000: cycles `STEP` must be stable to register; ≥1.
- `COUNT_BITS`, 32: width of `CYCLE_COUNT`.

Ports:
- `FPGA_GlobalClock`, in, 1: the single clock. Every flop sits in this domain.
- `RST`, in, 1: reset. **Synchronous, active-high.**
- `RUN`, in, 1: 1 = free-running ticks; 0 = step mode.
- `SPEED`, in, 1: reload select (1 fast, 0 slow).
- `STEP`, in, 1: asynchronous push button. Used only in step mode.
- `TICK`, out, 1: one-cycle base tick strobe.
- `CLOCK_BUS`, out, `5*NR_OF_CHANNELS`: channel i occupies bits `[5i+4:5i]`.
  - bit0 = clock level.
  - bit1 = inverted level.
  - bit2 = rising strobe.
  - bit3 = falling strobe.
  - bit4 = `TICK`.
- `CYCLE_COUNT`, out, `COUNT_BITS`: number of channel-0 rising edges.

## Operation
- **Reset values.**
  - Tick counter is loaded with `R-1`, where R is the reload selected by `SPEED`.
  - Every channel: level 0, phase counter = `(LOW_TICKS<<i)-1`.
  - `TICK`=0; all strobes 0; bit1=1; `CYCLE_COUNT`=0.
  - Step synchroniser and debounce state are cleared.
- **Tick generator in run mode (`RUN`=1).**
  - The counter decrements once per cycle.
  - At 0: `TICK`=1 for one cycle and the counter reloads with `R-1`.
  - R is sampled only at reload, so a `SPEED` change never shortens or extends the current period.
- **Tick generator in step mode (`RUN`=0).**
  - The counter holds its value, so switching back to run resumes the remaining count.
  - `STEP` passes through a 2-FF synchroniser and then a debounce counter.
  - The debounced level changes only after the synchronised input has been stable for `DEBOUNCE_CYCLES` consecutive cycles.
  - A debounced 0→1 transition produces exactly one `TICK`.
  - Pressing `STEP` while `RUN`=1 produces no tick. The debounced state still tracks the button, so a press held across a mode change does not fire.
- **Channel i.**
  - On each `TICK`: if the phase counter is 0, toggle the level and load `(HIGH_TICKS<<i)-1` (new level 1) or `(LOW_TICKS<<i)-1` (new level 0). Otherwise decrement.
  - The rise/fall strobe is high for exactly the cycle in which the level output first shows its new value.
  - Without a `TICK` the channel holds its state.
- **`CYCLE_COUNT`.** Increments in the cycle channel 0's rising strobe is high. Wraps modulo `2^COUNT_BITS`.
- **`RST` mid-operation** overrides every other input in that cycle and restores all reset values.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Run mode.** First `TICK` is in cycle R after `RST` deasserts (counts R-1..0); thereafter every R cycles.
- **Channel response.**
  - Level and strobe update in the cycle after `TICK`.
  - Channel i period = `((HIGH_TICKS+LOW_TICKS)<<i)` ticks.
  - First rising edge occurs after `LOW_TICKS<<i` ticks.
- **`CYCLE_COUNT`** updates one cycle after the channel-0 rising strobe.
- **Step latency.** `TICK` fires `2+DEBOUNCE_CYCLES` cycles after `STEP` first goes, and stays, high. Bounces shorter than `DEBOUNCE_CYCLES` are ignored.
- **`RUN` 1→0 on the cycle the counter hits 0.** That `TICK` still fires; the counter reloads and then freezes.

## Test plan
Parameters for all scenarios: `RELOAD_FAST`=4, `RELOAD_SLOW`=10, `NR_OF_CHANNELS`=2, `HIGH_TICKS`=`LOW_TICKS`=1, `DEBOUNCE_CYCLES`=3, `COUNT_BITS`=4.

1. **Reset and run fast.** Hold `RST` 2 cycles, then `RUN`=1, `SPEED`=1. Expect:
   - All outputs at reset values during reset.
   - `TICK` at cycles 4, 8, 12, …
   - Ch0 level toggles after each tick (period 8 cycles).
   - Ch1 toggles every 2 ticks (period 16 cycles).
   - `CYCLE_COUNT` 1, 2, … on each ch0 rise.
2. **Speed switch mid-period.** Set `SPEED`=0 at cycle 6. Expect:
   - Next `TICK` still at cycle 8.
   - Subsequent ticks at cycles 18, 28.
3. **Step mode with bounce.** Set `RUN`=0.
   - Pulse `STEP` high 2 cycles: no `TICK`.
   - Then hold `STEP` high 10 cycles: exactly one `TICK`, 5 cycles after the rise.
   - Release and press again: a second single `TICK`.
   - Tick counter is unchanged throughout.
4. **Mode resume.**
   - Freeze with `RUN`=0 when the counter = 2; wait 20 cycles; set `RUN`=1.
   - Expect `TICK` exactly 3 cycles later.
5. **Wrap and mid-run reset.**
   - After 16 ch0 rising edges, `CYCLE_COUNT` reads 0.
   - Assert `RST` for 1 cycle mid-period: all outputs return to reset values next cycle, and the first `TICK` comes R cycles after release.
